// File: rtl/btn_led_sequencer.sv
// Button/LED front end: debounces three raw buttons, selects a run mode and
// animates an LED pattern between a start press and timer_end.
module btn_led_sequencer #(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned STEP_CYC     = 25_000_000,
  parameter int unsigned MODE_W       = $clog2(NUM_MODES)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              mini_rst,
  input  logic              timer_end,
  input  logic              btn_up,
  input  logic              btn_dwn,
  input  logic              btn_start,
  output logic [MODE_W-1:0] mode,
  output logic              start,
  output logic              idle,
  output logic [LED_W-1:0]  LED
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC);
  localparam int unsigned STEP_W  = $clog2(STEP_CYC);
  localparam int unsigned NB      = 3;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DWN   = 1;
  localparam int unsigned B_START = 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [NB-1:0]     raw;
  logic [NB-1:0]     sync1;
  logic [NB-1:0]     sync2;
  logic [NB-1:0]     deb;
  logic [NB-1:0]     deb_q;
  logic [NB-1:0]     press;
  logic [NB-1:0]     armed;
  logic [1:0]        fill;
  logic [DB_W-1:0]   db_cnt [NB];
  state_t            state;
  logic [STEP_W-1:0] step_cnt;

  assign raw = {btn_start, btn_dwn, btn_up};

  function automatic logic [LED_W-1:0] onehot(input logic [MODE_W-1:0] m);
    return LED_W'(1) << m;
  endfunction

  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    return (m == MODE_W'(NUM_MODES - 1)) ? '0 : m + MODE_W'(1);
  endfunction

  function automatic logic [MODE_W-1:0] mode_dec(input logic [MODE_W-1:0] m);
    return (m == '0) ? MODE_W'(NUM_MODES - 1) : m - MODE_W'(1);
  endfunction

  function automatic logic [LED_W-1:0] init_pat(input logic [MODE_W-1:0] m);
    logic [LED_W-1:0] alt;
    alt = '0;
    for (int unsigned i = 0; i < LED_W; i += 2) alt[i] = 1'b1;
    case (32'(m))
      0:       return LED_W'(1);
      1:       return LED_W'(1) << (LED_W - 1);
      2:       return '0;
      3:       return alt;
      default: return '0;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] next_pat(input logic [MODE_W-1:0] m,
                                                input logic [LED_W-1:0]  v);
    case (32'(m))
      0:       return {v[LED_W-2:0], v[LED_W-1]};
      1:       return {v[0], v[LED_W-1:1]};
      2:       return (&v) ? '0 : {v[LED_W-2:0], 1'b1};
      3:       return ~v;
      default: return v + LED_W'(1);
    endcase
  endfunction

  // Synchronise, debounce and edge-detect the buttons. A button only arms once
  // it has been seen low after reset, so a press held through reset is ignored.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      armed <= '0;
      fill  <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      fill  <= {fill[0], 1'b1};
      press <= mini_rst ? '0 : (deb & ~deb_q & armed);
      for (int unsigned i = 0; i < NB; i++) begin
        if (fill[1] && !sync2[i]) armed[i] <= 1'b1;
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode selection / run control with registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      mode     <= '0;
      start    <= 1'b0;
      idle     <= 1'b1;
      LED      <= LED_W'(1);
      step_cnt <= '0;
    end else if (mini_rst) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      idle     <= 1'b1;
      LED      <= onehot(mode);
      step_cnt <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press[B_START]) begin
            state    <= S_RUN;
            start    <= 1'b1;
            idle     <= 1'b0;
            LED      <= init_pat(mode);
            step_cnt <= '0;
          end else if (press[B_UP] && !press[B_DWN]) begin
            mode <= mode_inc(mode);
            LED  <= onehot(mode_inc(mode));
          end else if (press[B_DWN] && !press[B_UP]) begin
            mode <= mode_dec(mode);
            LED  <= onehot(mode_dec(mode));
          end
        end
        S_RUN: begin
          if (timer_end) begin
            state    <= S_IDLE;
            idle     <= 1'b1;
            LED      <= onehot(mode);
            step_cnt <= '0;
          end else if (step_cnt == STEP_W'(STEP_CYC - 1)) begin
            step_cnt <= '0;
            LED      <= next_pat(mode, LED);
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_led_sequencer.sv
// Self-checking bench for btn_led_sequencer: randomized bounce, run lengths and
// end points, compared against an arithmetic pattern/mode model.
`timescale 1ns/1ps
module tb_btn_led_sequencer;

  localparam int unsigned NUM_MODES    = 5;
  localparam int unsigned LED_W        = 8;
  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned STEP_CYC     = 3;
  localparam int unsigned MODE_W       = $clog2(NUM_MODES);

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              mini_rst;
  logic              timer_end;
  logic              btn_up;
  logic              btn_dwn;
  logic              btn_start;
  logic [MODE_W-1:0] mode;
  logic              start;
  logic              idle;
  logic [LED_W-1:0]  LED;

  int checks = 0;
  int errors = 0;
  int exp_mode = 0;

  always #5 sys_clk = ~sys_clk;

  btn_led_sequencer #(
    .NUM_MODES   (NUM_MODES),
    .LED_W       (LED_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .STEP_CYC    (STEP_CYC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mini_rst (mini_rst),
    .timer_end(timer_end),
    .btn_up   (btn_up),
    .btn_dwn  (btn_dwn),
    .btn_start(btn_start),
    .mode     (mode),
    .start    (start),
    .idle     (idle),
    .LED      (LED)
  );

  // Expected pattern after k steps in mode m, from the step rules directly.
  function automatic logic [LED_W-1:0] exp_pat(int m, int k);
    int n;
    case (m)
      0: return LED_W'(1 << (k % LED_W));
      1: return LED_W'((1 << (LED_W - 1)) >> (k % LED_W));
      2: begin n = k % (LED_W + 1); return LED_W'((1 << n) - 1); end
      3: return (k % 2 == 0) ? 8'h55 : 8'hAA;
      default: return LED_W'(k % (1 << LED_W));
    endcase
  endfunction

  function automatic logic [LED_W-1:0] exp_onehot(int m);
    return LED_W'(1 << m);
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press_btns(logic u, logic d, logic s);
    @(negedge sys_clk);
    btn_up = u; btn_dwn = d; btn_start = s;
    cycles(12);
    btn_up = 1'b0; btn_dwn = 1'b0; btn_start = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; mini_rst = 1'b0; timer_end = 1'b0;
    btn_up = 1'b0; btn_dwn = 1'b0; btn_start = 1'b0;
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({mode, idle, start, LED} !== {MODE_W'(0), 1'b1, 1'b0, 8'h01}) begin
      errors++;
      $display("FAIL reset_async: mode=%0d idle=%b start=%b LED=%h required 0 1 0 01",
               mode, idle, start, LED);
    end
    exp_mode = 0;
    cycles(2);
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({mode, idle, start, LED} !== {MODE_W'(0), 1'b1, 1'b0, 8'h01}) begin
        errors++;
        $display("FAIL reset_quiet cyc %0d: mode=%0d idle=%b start=%b LED=%h required 0 1 0 01",
                 i, mode, idle, start, LED);
      end
    end
  endtask

  task automatic test_debounce_wrap();
    int c;
    int d;
    c = 0;
    @(negedge sys_clk);
    while (c < 20) begin
      btn_dwn = ~btn_dwn;
      d = int'($urandom_range(1, 3));
      cycles(d);
      c += d;
      checks++;
      if (mode !== MODE_W'(exp_mode)) begin
        errors++;
        $display("FAIL bounce_mode: mode=%0d required %0d", mode, exp_mode);
      end
    end
    btn_dwn = 1'b0;
    cycles(1);
    btn_dwn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge sys_clk);
      if (i == 7) begin
        checks++;
        if (mode !== MODE_W'(exp_mode)) begin
          errors++;
          $display("FAIL dwn_latency_early: mode=%0d required %0d", mode, exp_mode);
        end
      end
      if (i == 8) begin
        exp_mode = (exp_mode + NUM_MODES - 1) % NUM_MODES;
        checks++;
        if (mode !== MODE_W'(exp_mode) || LED !== exp_onehot(exp_mode)) begin
          errors++;
          $display("FAIL dwn_wrap: mode=%0d LED=%h required %0d %h",
                   mode, LED, exp_mode, exp_onehot(exp_mode));
        end
      end
    end
    btn_dwn = 1'b0;
    cycles(10);
    for (int i = 0; i < 2; i++) begin
      press_btns(1'b1, 1'b0, 1'b0);
      exp_mode = (exp_mode + 1) % NUM_MODES;
      checks++;
      if (mode !== MODE_W'(exp_mode) || LED !== exp_onehot(exp_mode) || idle !== 1'b1) begin
        errors++;
        $display("FAIL up_press %0d: mode=%0d LED=%h idle=%b required %0d %h 1",
                 i, mode, LED, idle, exp_mode, exp_onehot(exp_mode));
      end
    end
  endtask

  task automatic test_simultaneous();
    int w;
    press_btns(1'b1, 1'b1, 1'b0);
    checks++;
    if (mode !== MODE_W'(exp_mode) || idle !== 1'b1) begin
      errors++;
      $display("FAIL up_dwn_same: mode=%0d idle=%b required %0d 1", mode, idle, exp_mode);
    end
    @(negedge sys_clk);
    btn_up = 1'b1; btn_start = 1'b1;
    w = 0;
    while (start !== 1'b1 && w < 20) begin @(negedge sys_clk); w++; end
    checks++;
    if (w == 20 || mode !== MODE_W'(exp_mode) || idle !== 1'b0) begin
      errors++;
      $display("FAIL start_up_same: waited=%0d mode=%0d idle=%b required start mode %0d idle 0",
               w, mode, idle, exp_mode);
    end
    btn_up = 1'b0; btn_start = 1'b0;
    cycles(10);
    timer_end = 1'b1;
    @(negedge sys_clk);
    timer_end = 1'b0;
    checks++;
    if (idle !== 1'b1 || mode !== MODE_W'(exp_mode)) begin
      errors++;
      $display("FAIL start_up_end: idle=%b mode=%0d required 1 %0d", idle, mode, exp_mode);
    end
    cycles(4);
  endtask

  // Select mode m, start, follow nsteps steps, then end with timer_end (or
  // mini_rst plus timer_end) on a cycle where a step would also fall.
  task automatic test_run(int m, int nsteps, bit use_mini, bit poke);
    int w;
    int last;
    while (exp_mode != m) begin
      press_btns(1'b1, 1'b0, 1'b0);
      exp_mode = (exp_mode + 1) % NUM_MODES;
      checks++;
      if (mode !== MODE_W'(exp_mode)) begin
        errors++;
        $display("FAIL nav_mode: mode=%0d required %0d", mode, exp_mode);
      end
    end
    @(negedge sys_clk);
    btn_start = 1'b1;
    w = 0;
    while (start !== 1'b1 && w < 20) begin @(negedge sys_clk); w++; end
    btn_start = 1'b0;
    checks++;
    if (w == 20) begin
      errors++;
      $display("FAIL run_start_timeout m%0d: start=%b required 1", m, start);
      return;
    end
    checks++;
    if (LED !== exp_pat(m, 0) || idle !== 1'b0 || mode !== MODE_W'(exp_mode)) begin
      errors++;
      $display("FAIL run_entry m%0d: LED=%h idle=%b mode=%0d required %h 0 %0d",
               m, LED, idle, mode, exp_pat(m, 0), exp_mode);
    end
    last = int'(STEP_CYC) * nsteps + int'(STEP_CYC) - 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge sys_clk);
      checks++;
      if (LED !== exp_pat(m, c / int'(STEP_CYC)) || start !== 1'b0 || idle !== 1'b0 ||
          mode !== MODE_W'(exp_mode)) begin
        errors++;
        $display("FAIL run_step m%0d c%0d: LED=%h start=%b idle=%b mode=%0d required %h 0 0 %0d",
                 m, c, LED, start, idle, mode, exp_pat(m, c / int'(STEP_CYC)), exp_mode);
      end
      if (poke) begin
        if (c == 4)  btn_up = 1'b1;
        if (c == 16) btn_up = 1'b0;
        if (c == 30) btn_dwn = 1'b1;
        if (c == 42) btn_dwn = 1'b0;
        if (c == 60) btn_start = 1'b1;
        if (c == 72) btn_start = 1'b0;
      end
    end
    timer_end = 1'b1;
    mini_rst = use_mini;
    @(negedge sys_clk);
    mini_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (idle !== 1'b1 || start !== 1'b0 || LED !== exp_onehot(exp_mode) ||
          mode !== MODE_W'(exp_mode)) begin
        errors++;
        $display("FAIL run_end m%0d i%0d: idle=%b start=%b LED=%h mode=%0d required 1 0 %h %0d",
                 m, i, idle, start, LED, mode, exp_onehot(exp_mode), exp_mode);
      end
      @(negedge sys_clk);
    end
    timer_end = 1'b0;
    cycles(6);
  endtask

  task automatic test_mini_rst();
    test_run(0, 2 + int'($urandom_range(0, 3)), 1'b1, 1'b0);
    test_run(0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_held_reset();
    @(negedge sys_clk);
    btn_up = 1'b1;
    cycles(3);
    sys_rst = 1'b1;
    cycles(2);
    sys_rst = 1'b0;
    exp_mode = 0;
    cycles(20);
    checks++;
    if (mode !== MODE_W'(0) || idle !== 1'b1) begin
      errors++;
      $display("FAIL held_through_reset: mode=%0d idle=%b required 0 1", mode, idle);
    end
    btn_up = 1'b0;
    cycles(10);
    press_btns(1'b1, 1'b0, 1'b0);
    exp_mode = 1;
    checks++;
    if (mode !== MODE_W'(1) || LED !== 8'h02) begin
      errors++;
      $display("FAIL held_then_press: mode=%0d LED=%h required 1 02", mode, LED);
    end
  endtask

  task automatic test_reset_midrun();
    int w;
    press_btns(1'b1, 1'b0, 1'b0);
    exp_mode = (exp_mode + 1) % NUM_MODES;
    @(negedge sys_clk);
    btn_start = 1'b1;
    w = 0;
    while (start !== 1'b1 && w < 20) begin @(negedge sys_clk); w++; end
    btn_start = 1'b0;
    cycles(int'($urandom_range(1, 7)));
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({mode, idle, start, LED} !== {MODE_W'(0), 1'b1, 1'b0, 8'h01} || w == 20) begin
      errors++;
      $display("FAIL reset_midrun: waited=%0d mode=%0d idle=%b start=%b LED=%h required 0 1 0 01",
               w, mode, idle, start, LED);
    end
    exp_mode = 0;
    cycles(2);
    sys_rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_debounce_wrap();
    test_simultaneous();
    test_run(0, 9 + int'($urandom_range(0, 4)), 1'b0, 1'b0);
    test_run(1, 9 + int'($urandom_range(0, 4)), 1'b0, 1'b0);
    test_run(2, 9 + int'($urandom_range(0, 4)), 1'b0, 1'b0);
    test_run(3, 2 + int'($urandom_range(0, 3)), 1'b0, 1'b0);
    test_run(4, 256 + int'($urandom_range(1, 3)), 1'b0, 1'b1);
    test_mini_rst();
    test_held_reset();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
